// File: rtl/retire_trace_buffer_if.sv
// Retire-side and trace-sink signals of the retire trace buffer.
// The retire group flows into the buffer; the out group is a valid/ready drain port.
interface retire_trace_buffer_if #(
   parameter int CNT_W = 16
);
   logic             ret_valid;
   logic [15:0]      ret_pc;
   logic             ret_regwrite;
   logic [2:0]       ret_wreg;
   logic [15:0]      ret_wdata;
   logic             ret_memread;
   logic             ret_memwrite;
   logic [15:0]      ret_memaddr;
   logic [15:0]      ret_memdata;
   logic             ret_halt;

   logic             out_valid;
   logic             out_ready;
   logic [CNT_W-1:0] out_inum;
   logic [15:0]      out_pc;
   logic [2:0]       out_kind;
   logic [2:0]       out_reg;
   logic [15:0]      out_rval;
   logic [15:0]      out_addr;
   logic [15:0]      out_mval;

   modport slave (
      input  ret_valid, ret_pc, ret_regwrite, ret_wreg, ret_wdata,
             ret_memread, ret_memwrite, ret_memaddr, ret_memdata, ret_halt,
      input  out_ready,
      output out_valid, out_inum, out_pc, out_kind, out_reg, out_rval, out_addr, out_mval
   );

   modport master (
      output ret_valid, ret_pc, ret_regwrite, ret_wreg, ret_wdata,
             ret_memread, ret_memwrite, ret_memaddr, ret_memdata, ret_halt,
      output out_ready,
      input  out_valid, out_inum, out_pc, out_kind, out_reg, out_rval, out_addr, out_mval
   );
endinterface

// File: rtl/retire_trace_buffer.sv
// Commit-trace capture: classifies each retiring instruction into a numbered record,
// buffers it in a FIFO for a valid/ready sink, and tracks cycle/instruction counts and halt.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_RUN    | capturing retiring instructions
// ST_DRAIN  | halt record enqueued, capture stopped, FIFO still draining
// ST_DONE   | halted and FIFO empty
module retire_trace_buffer #(
   parameter int DEPTH = 16,
   parameter int CNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   retire_trace_buffer_if.slave trc,
   output logic [CNT_W-1:0]     cycle_count,
   output logic [CNT_W-1:0]     inst_count,
   output logic                 overflow,
   output logic                 halted,
   output logic                 done
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [2:0] KIND_NOP  = 3'd0;
   localparam logic [2:0] KIND_ALU  = 3'd1;
   localparam logic [2:0] KIND_LD   = 3'd2;
   localparam logic [2:0] KIND_ST   = 3'd3;
   localparam logic [2:0] KIND_STU  = 3'd4;
   localparam logic [2:0] KIND_HALT = 3'd5;

   typedef struct packed {
      logic [CNT_W-1:0] inum;
      logic [15:0]      pc;
      logic [2:0]       kind;
      logic [2:0]       rg;
      logic [15:0]      rval;
      logic [15:0]      addr;
      logic [15:0]      mval;
   } rec_t;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t         state, state_nx;
   rec_t           mem [DEPTH];
   rec_t           cap_rec;
   rec_t           head_rec;
   logic [AW:0]    wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx;
   logic           empty, full, deq;
   logic           capture, enq, drop, count_inst, halt_enq;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign deq   = !empty && trc.out_ready;

   // A halt that meets a full FIFO is neither dropped nor counted; upstream keeps it asserted.
   assign capture    = trc.ret_valid && (state == ST_RUN);
   assign enq        = capture && (!full || deq);
   assign drop       = capture && !trc.ret_halt && full && !deq;
   assign count_inst = capture && (!trc.ret_halt || enq);
   assign halt_enq   = enq && trc.ret_halt;

   assign wr_ptr_nx = wr_ptr + (AW+1)'(enq);
   assign rd_ptr_nx = rd_ptr + (AW+1)'(deq);

   always_comb begin
      cap_rec      = '0;
      cap_rec.inum = inst_count;
      cap_rec.pc   = trc.ret_pc;
      if (trc.ret_halt) begin
         cap_rec.kind = KIND_HALT;
      end else if (trc.ret_regwrite && trc.ret_memwrite) begin
         cap_rec.kind = KIND_STU;
         cap_rec.rg   = trc.ret_wreg;
         cap_rec.rval = trc.ret_wdata;
         cap_rec.addr = trc.ret_memaddr;
         cap_rec.mval = trc.ret_memdata;
      end else if (trc.ret_memwrite) begin
         cap_rec.kind = KIND_ST;
         cap_rec.addr = trc.ret_memaddr;
         cap_rec.mval = trc.ret_memdata;
      end else if (trc.ret_regwrite && trc.ret_memread) begin
         cap_rec.kind = KIND_LD;
         cap_rec.rg   = trc.ret_wreg;
         cap_rec.rval = trc.ret_wdata;
         cap_rec.addr = trc.ret_memaddr;
      end else if (trc.ret_regwrite) begin
         cap_rec.kind = KIND_ALU;
         cap_rec.rg   = trc.ret_wreg;
         cap_rec.rval = trc.ret_wdata;
      end else begin
         cap_rec.kind = KIND_NOP;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_RUN:   if (halt_enq) state_nx = ST_DRAIN;
         ST_DRAIN: if (wr_ptr_nx == rd_ptr_nx) state_nx = ST_DONE;
         ST_DONE:  state_nx = ST_DONE;
         default:  state_nx = ST_RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ST_RUN;
      end else begin
         state <= state_nx;
      end
   end

   assign halted = (state != ST_RUN);
   assign done   = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         cycle_count <= '0;
         inst_count  <= '0;
         overflow    <= 1'b0;
      end else begin
         wr_ptr      <= wr_ptr_nx;
         rd_ptr      <= rd_ptr_nx;
         cycle_count <= cycle_count + 1'b1;
         if (count_inst) inst_count <= inst_count + 1'b1;
         if (drop)       overflow   <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && enq) mem[wr_ptr[AW-1:0]] <= cap_rec;
   end

   // Payload is forced to zero while empty so stale storage never leaks out.
   assign head_rec = empty ? '0 : mem[rd_ptr[AW-1:0]];

   assign trc.out_valid = !empty;
   assign trc.out_inum  = head_rec.inum;
   assign trc.out_pc    = head_rec.pc;
   assign trc.out_kind  = head_rec.kind;
   assign trc.out_reg   = head_rec.rg;
   assign trc.out_rval  = head_rec.rval;
   assign trc.out_addr  = head_rec.addr;
   assign trc.out_mval  = head_rec.mval;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Self-checking bench for retire_trace_buffer: directed scenarios plus randomized
// backpressure, checked every cycle against a queue-based reference model.
module tb_retire_trace_buffer;
   localparam int DEPTH = 16;
   localparam int CNT_W = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   retire_trace_buffer_if #(.CNT_W(CNT_W)) trc();
   logic [CNT_W-1:0] cycle_count, inst_count;
   logic             overflow, halted, done;

   retire_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .trc         (trc),
      .cycle_count (cycle_count),
      .inst_count  (inst_count),
      .overflow    (overflow),
      .halted      (halted),
      .done        (done)
   );

   typedef struct {
      logic [15:0] inum, pc, rval, addr, mval;
      logic [2:0]  kind, rg;
   } rec_t;

   typedef struct {
      bit          valid, rw, mr, mw, halt;
      logic [15:0] pc, wdata, maddr, mdata;
      logic [2:0]  wreg;
   } ret_t;

   rec_t q[$];
   int   m_cyc, m_inst, n_deq;
   bit   m_ovf, m_halted;
   int   n_cmp, n_err;
   bit   stall_prev;
   logic [63:0] prev_head;

   task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic ret_t mk(logic [15:0] pc, bit rw, logic [2:0] wreg, logic [15:0] wdata,
                               bit mr, bit mw, logic [15:0] maddr, logic [15:0] mdata, bit halt);
      ret_t r;
      r.valid = 1; r.pc = pc; r.rw = rw; r.wreg = wreg; r.wdata = wdata;
      r.mr = mr; r.mw = mw; r.maddr = maddr; r.mdata = mdata; r.halt = halt;
      return r;
   endfunction

   function automatic ret_t idle();
      ret_t r = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
      r.valid = 0;
      return r;
   endfunction

   function automatic ret_t rnd_ret();
      ret_t r = mk(16'($urandom), 1'($urandom), 3'($urandom), 16'($urandom), 1'($urandom),
                   1'($urandom), 16'($urandom), 16'($urandom), 0);
      r.valid = ($urandom_range(99) < 45);
      return r;
   endfunction

   // Reference classification: highest-priority class wins, non-applicable fields are zero.
   function automatic rec_t classify(ret_t r);
      rec_t c = '{default: '0};
      c.pc = r.pc;
      if (r.halt) c.kind = 5;
      else if (r.rw && r.mw) begin c.kind = 4; c.rg = r.wreg; c.rval = r.wdata; c.addr = r.maddr; c.mval = r.mdata; end
      else if (r.mw)         begin c.kind = 3; c.addr = r.maddr; c.mval = r.mdata; end
      else if (r.rw && r.mr) begin c.kind = 2; c.rg = r.wreg; c.rval = r.wdata; c.addr = r.maddr; end
      else if (r.rw)         begin c.kind = 1; c.rg = r.wreg; c.rval = r.wdata; end
      else c.kind = 0;
      return c;
   endfunction

   task automatic drive(ret_t r, bit ready);
      trc.ret_valid    = r.valid;
      trc.ret_pc       = r.pc;
      trc.ret_regwrite = r.rw;
      trc.ret_wreg     = r.wreg;
      trc.ret_wdata    = r.wdata;
      trc.ret_memread  = r.mr;
      trc.ret_memwrite = r.mw;
      trc.ret_memaddr  = r.maddr;
      trc.ret_memdata  = r.mdata;
      trc.ret_halt     = r.halt;
      trc.out_ready    = ready;
   endtask

   task automatic model_update(ret_t r, bit ready);
      int   sz = q.size();
      bit   deq = (sz > 0) && ready;
      rec_t nr;
      if (deq) begin
         void'(q.pop_front());
         n_deq++;
      end
      if (r.valid && !m_halted) begin
         nr = classify(r);
         nr.inum = 16'(m_inst);
         if (sz < DEPTH || deq) begin
            q.push_back(nr);
            m_inst++;
            if (r.halt) m_halted = 1;
         end else if (!r.halt) begin
            m_ovf = 1;
            m_inst++;
         end
      end
      m_cyc++;
   endtask

   task automatic check_outputs();
      rec_t h = '{default: '0};
      if (q.size() > 0) h = q[0];
      check_val("out_valid", trc.out_valid, q.size() > 0);
      check_val("out_inum", trc.out_inum, h.inum);
      check_val("out_pc", trc.out_pc, h.pc);
      check_val("out_kind", trc.out_kind, h.kind);
      check_val("out_reg", trc.out_reg, h.rg);
      check_val("out_rval", trc.out_rval, h.rval);
      check_val("out_addr", trc.out_addr, h.addr);
      check_val("out_mval", trc.out_mval, h.mval);
      check_val("cycle_count", cycle_count, 16'(m_cyc));
      check_val("inst_count", inst_count, 16'(m_inst));
      check_val("overflow", overflow, m_ovf);
      check_val("halted", halted, m_halted);
      check_val("done", done, m_halted && q.size() == 0);
   endtask

   task automatic step(ret_t r, bit ready);
      logic [63:0] head;
      @(negedge clk);
      check_outputs();
      head = {trc.out_inum, trc.out_pc, trc.out_kind, trc.out_reg, trc.out_rval, 10'd0};
      if (stall_prev) check_val("stall_stable", head, prev_head);
      stall_prev = trc.out_valid && !ready;
      prev_head  = head;
      drive(r, ready);
      model_update(r, ready);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 0;
      drive(idle(), 0);
      repeat (2) @(negedge clk);
      q.delete();
      m_cyc = 0; m_inst = 0; m_ovf = 0; m_halted = 0; stall_prev = 0;
      check_outputs();
      rst = 1;
      model_update(idle(), 0);
   endtask

   initial begin
      int budget;
      n_cmp = 0; n_err = 0; n_deq = 0;
      rst = 0;
      drive(idle(), 0);
      do_reset();

      // Mixed stream with the sink always ready.
      step(mk(16'h0000, 1, 3, 16'h1234, 0, 0, 0, 0, 0), 1);
      step(mk(16'h0002, 1, 1, 16'h5A5A, 1, 0, 16'h0040, 16'h7777, 0), 1);
      step(mk(16'h0004, 0, 5, 16'h9999, 0, 1, 16'h0042, 16'hBEEF, 0), 1);
      repeat (4) step(idle(), 1);

      // 17 captures into a stalled sink, then drain.
      do_reset();
      for (int i = 0; i < 17; i++) step(mk(16'(2*i), 1, 3'(i), 16'(i), 0, 0, 0, 0, 0), 0);
      step(idle(), 0);
      check_val("ovf_set", overflow, 1);
      check_val("ovf_inst17", inst_count, 17);
      repeat (18) step(idle(), 1);

      // Full FIFO with simultaneous dequeue and capture.
      do_reset();
      for (int i = 0; i < 16; i++) step(mk(16'(i), 1, 2, 16'(i), 0, 0, 0, 0, 0), 0);
      step(mk(16'h00F0, 0, 0, 0, 0, 1, 16'h0010, 16'h1111, 0), 1);
      step(idle(), 0);
      check_val("full_deq_noovf", overflow, 0);
      repeat (18) step(idle(), 1);

      // Halt after three NOPs, extra retires ignored, then drain to done.
      do_reset();
      for (int i = 0; i < 3; i++) step(mk(16'(2*i), 0, 0, 0, 0, 0, 0, 0, 0), 0);
      step(mk(16'h0008, 0, 0, 0, 0, 0, 0, 0, 1), 0);
      for (int i = 0; i < 3; i++) step(mk(16'h0100, 1, 1, 16'hAAAA, 0, 0, 0, 0, 0), 0);
      check_val("halt_inst", inst_count, 4);
      repeat (6) step(idle(), 1);
      check_val("halt_done", done, 1);

      // Halt arriving at a full FIFO is held until it fits.
      do_reset();
      for (int i = 0; i < 16; i++) step(mk(16'(i), 1, 4, 16'(i), 0, 0, 0, 0, 0), 0);
      repeat (3) step(mk(16'h0200, 0, 0, 0, 0, 0, 0, 0, 1), 0);
      step(mk(16'h0200, 0, 0, 0, 0, 0, 0, 0, 1), 1);
      repeat (20) step(idle(), 1);

      // Randomized traffic with random backpressure over 200 drained records.
      do_reset();
      n_deq = 0;
      budget = 0;
      while (n_deq < 200 && budget < 5000) begin
         step(rnd_ret(), $urandom_range(99) < 60);
         budget++;
      end
      if (budget >= 5000) check_val("rand_budget", 0, 1);
      repeat (20) step(idle(), 1);

      @(negedge clk);
      check_outputs();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
